// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the sync FIFO read-side stream adapter.
// Holds the skid buffer state encoding; the encoding doubles as the occupancy count.
package sync_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Upstream synchronous FIFO with registered read data (o_data valid one cycle after i_pop).
// Flush clears the contents; pointers wrap naturally, so DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == LP_FULL);
  assign o_level   = r_count;
  assign o_data    = r_data;
  assign w_do_push = i_push & ~o_full & ~flush;
  assign w_do_pop  = i_pop & ~o_empty & ~flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Two-entry skid buffer converting a sync FIFO read port (one-cycle read latency) into a valid/ready stream.
// Define SYNC_FIFO_RD_STREAM_CNT_EN to add the 16-bit xfer_cnt delivered-beat counter output.
module sync_fifo_rd_stream
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
  output logic [15:0]      xfer_cnt,
`endif
  output logic [1:0]       occupancy
);

  localparam logic [2:0] LP_DEPTH = 3'(SKID_DEPTH);

  skid_state_e      r_state;
  skid_state_e      w_next_state;
  logic             r_inflight;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_xfer;
  logic             w_capture;
  logic [2:0]       w_budget;

  assign w_xfer    = m_valid & m_ready;
  assign w_capture = r_inflight & ~flush;
  // Entries held plus the word already returning, minus the one leaving this cycle.
  assign w_budget  = {1'b0, occupancy} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign fifo_pop  = rst_n & ~fifo_empty & ~flush & (w_budget < LP_DEPTH);
  assign m_data    = r_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = SKID_EMPTY;
    end else begin
      case (r_state)
        SKID_EMPTY: if (w_capture) w_next_state = SKID_ONE;
        SKID_ONE: begin
          if (w_capture && !w_xfer) begin
            w_next_state = SKID_TWO;
          end else if (!w_capture && w_xfer) begin
            w_next_state = SKID_EMPTY;
          end
        end
        SKID_TWO:   if (w_xfer && !w_capture) w_next_state = SKID_ONE;
        default:    w_next_state = SKID_EMPTY;
      endcase
    end
  end

  always_comb begin
    occupancy = 2'd0;
    m_valid   = 1'b0;
    case (r_state)
      SKID_ONE: begin
        occupancy = 2'd1;
        m_valid   = 1'b1;
      end
      SKID_TWO: begin
        occupancy = 2'd2;
        m_valid   = 1'b1;
      end
      default: begin
        occupancy = 2'd0;
        m_valid   = 1'b0;
      end
    endcase
  end

  // Pop is already suppressed during flush, so this also drops the in-flight marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_pop;
    end
  end

  // A returning word lands at the head if the buffer is draining to empty, else behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!flush) begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_capture) r_head <= fifo_data;
        end
        SKID_ONE: begin
          if (w_capture && w_xfer) begin
            r_head <= fifo_data;
          end else if (w_capture) begin
            r_tail <= fifo_data;
          end
        end
        SKID_TWO: begin
          if (w_xfer) begin
            r_head <= r_tail;
            if (w_capture) r_tail <= fifo_data;
          end
        end
        default: begin
          r_head <= r_head;
        end
      endcase
    end
  end

`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (flush) begin
      r_xfer_cnt <= '0;
    end else if (w_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream fed by a DEPTH=4 sync_fifo; expected beats come from a queue of pushed words.
// Build with SYNC_FIFO_RD_STREAM_CNT_EN defined to also exercise the xfer_cnt counter and its wrap.
module tb_sync_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       push;
  logic [7:0] pushData;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       fifoPop;
  logic [7:0] fifoData;
  logic [2:0] fifoLevel;
  logic       mValid;
  logic       mReady;
  logic [7:0] mData;
  logic [1:0] occupancy;
`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
  logic [15:0] xferCnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];
  int unsigned cntModel = 0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .DEPTH(4)) upstream (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_push(push), .i_data(pushData), .i_pop(fifoPop),
    .o_data(fifoData), .o_empty(fifoEmpty), .o_full(fifoFull), .o_level(fifoLevel)
  );

  sync_fifo_rd_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fifo_empty(fifoEmpty), .fifo_data(fifoData), .fifo_pop(fifoPop),
    .m_valid(mValid), .m_ready(mReady), .m_data(mData),
`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
    .xfer_cnt(xferCnt),
`endif
    .occupancy(occupancy)
  );

  // Model bookkeeping for the cycle just driven, then move to posedge+1 of the next cycle.
  task automatic advance();
    if (flush) begin
      expQ.delete();
      cntModel = 0;
    end else begin
      if (push && !fifoFull) expQ.push_back(pushData);
      if (mValid && mReady) cntModel = (cntModel + 1) & 32'hFFFF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pushData = 8'h00; mReady = 1'b0;
    #2;
    checks++;
    if (mValid !== 1'b0 || occupancy !== 2'd0 || mData !== 8'h00 || fifoPop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state valid=%b occ=%0d data=%h pop=%b required 0/0/00/0", mValid, occupancy, mData, fifoPop);
    end
`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
    checks++;
    if (xferCnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_cnt got=%h required=0000", xferCnt);
    end
`endif
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int firstPop = -1, firstValid = -1, firstBeat = -1, lastBeat = -1, nBeats = 0;
    logic [7:0] expV;
    $display("[TB] latency and streaming");
    mReady = 1'b1;
    for (int c = 0; c < 30; c++) begin
      push = (c < 4);
      pushData = 8'(c);
      #1;
      if (fifoPop && firstPop < 0) firstPop = c;
      if (mValid && firstValid < 0) firstValid = c;
      if (mValid && mReady) begin
        checks++;
        if (firstBeat < 0) firstBeat = c;
        lastBeat = c;
        nBeats++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL latency_beat got=%h required=no beat", mData);
        end else begin
          expV = expQ.pop_front();
          if (mData !== expV) begin
            errors++;
            $display("[TB] FAIL latency_beat got=%h required=%h", mData, expV);
          end
        end
      end
      advance();
    end
    push = 1'b0;
    checks++;
    if (firstPop < 0 || firstValid - firstPop != 2) begin
      errors++;
      $display("[TB] FAIL first_valid_latency got=%0d required=2", firstValid - firstPop);
    end
    checks++;
    if (nBeats != 4 || lastBeat - firstBeat != 3) begin
      errors++;
      $display("[TB] FAIL stream_back_to_back beats=%0d span=%0d required 4/3", nBeats, lastBeat - firstBeat);
    end
  endtask

  task automatic test_backpressure();
    int firstBeat = -1, lastBeat = -1, nBeats = 0;
    logic [7:0] expV;
    $display("[TB] backpressure");
    mReady = 1'b0;
    for (int c = 0; c < 12; c++) begin
      push = (c < 4);
      pushData = 8'h10 + 8'(c);
      #1;
      if (mValid) begin
        checks++;
        if (mData !== 8'h10) begin
          errors++;
          $display("[TB] FAIL stall_head got=%h required=10", mData);
        end
      end
      advance();
    end
    push = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd2 || fifoPop !== 1'b0 || fifoLevel !== 3'd2 || mData !== 8'h10 || mValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_full occ=%0d pop=%b level=%0d data=%h valid=%b required 2/0/2/10/1",
               occupancy, fifoPop, fifoLevel, mData, mValid);
    end
    mReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mValid && mReady) begin
        checks++;
        if (firstBeat < 0) firstBeat = c;
        lastBeat = c;
        nBeats++;
        expV = (expQ.size() != 0) ? expQ.pop_front() : 8'hXX;
        if (mData !== expV) begin
          errors++;
          $display("[TB] FAIL release_beat got=%h required=%h", mData, expV);
        end
      end
      advance();
      #1;
    end
    checks++;
    if (nBeats != 4 || firstBeat != 0 || lastBeat != 3) begin
      errors++;
      $display("[TB] FAIL release_back_to_back beats=%0d first=%0d last=%0d required 4/0/3", nBeats, firstBeat, lastBeat);
    end
  endtask

  task automatic test_toggle_ready();
    int pushed = 0, nBeats = 0;
    logic [7:0] expV;
    $display("[TB] toggling ready");
    for (int c = 0; c < 80 && nBeats < 8; c++) begin
      mReady = (c % 2) == 0;
      push = (pushed < 8) && !fifoFull;
      pushData = 8'hA0 + 8'(pushed);
      #1;
      if (push && !fifoFull) pushed++;
      checks++;
      if (occupancy > 2'd2 || mValid !== (occupancy != 2'd0)) begin
        errors++;
        $display("[TB] FAIL toggle_occupancy occ=%0d valid=%b required occ<=2 and valid=(occ!=0)", occupancy, mValid);
      end
      if (mValid && mReady) begin
        checks++;
        nBeats++;
        expV = (expQ.size() != 0) ? expQ.pop_front() : 8'hXX;
        if (mData !== expV) begin
          errors++;
          $display("[TB] FAIL toggle_beat got=%h required=%h", mData, expV);
        end
      end
      advance();
    end
    push = 1'b0;
    checks++;
    if (nBeats != 8 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL toggle_count beats=%0d left=%0d required 8/0", nBeats, expQ.size());
    end
  endtask

  task automatic test_flush();
    int nBeats = 0;
    logic [7:0] firstVal = 8'h00;
    logic [7:0] expV;
    $display("[TB] flush with a word in flight");
    mReady = 1'b0;
    push = 1'b1; pushData = 8'h33;
    advance();
    push = 1'b0;
    advance();
    advance();
    #1;
    checks++;
    if (occupancy !== 2'd1) begin
      errors++;
      $display("[TB] FAIL flush_setup occ=%0d required=1", occupancy);
    end
    push = 1'b1; pushData = 8'h44;
    advance();
    push = 1'b0;
    #1;
    checks++;
    if (fifoPop !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("[TB] FAIL flush_pop pop=%b occ=%0d required 1/1", fifoPop, occupancy);
    end
    advance();
    flush = 1'b1;
    #1;
    checks++;
    if (mValid !== 1'b1 || fifoPop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_cycle valid=%b pop=%b required 1/0", mValid, fifoPop);
    end
    advance();
    flush = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd0 || mValid !== 1'b0 || fifoEmpty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_after occ=%0d valid=%b empty=%b required 0/0/1", occupancy, mValid, fifoEmpty);
    end
    push = 1'b1; pushData = 8'h55; mReady = 1'b1;
    advance();
    push = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mValid && mReady) begin
        checks++;
        if (nBeats == 0) firstVal = mData;
        nBeats++;
        expV = (expQ.size() != 0) ? expQ.pop_front() : 8'hXX;
        if (mData !== expV) begin
          errors++;
          $display("[TB] FAIL flush_beat got=%h required=%h", mData, expV);
        end
      end
      advance();
    end
    checks++;
    if (nBeats != 1 || firstVal !== 8'h55) begin
      errors++;
      $display("[TB] FAIL flush_first_beat beats=%0d first=%h required 1/55", nBeats, firstVal);
    end
  endtask

  task automatic test_random();
    logic prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic [7:0] expV;
    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      push = $urandom_range(0, 1) == 1;
      pushData = 8'($urandom);
      mReady = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      #1;
      checks++;
      if (occupancy > 2'd2 || mValid !== (occupancy != 2'd0) || (flush && fifoPop)) begin
        errors++;
        $display("[TB] FAIL random_invariant occ=%0d valid=%b pop=%b flush=%b", occupancy, mValid, fifoPop, flush);
      end
      if (prevStall && mValid) begin
        checks++;
        if (mData !== prevData) begin
          errors++;
          $display("[TB] FAIL random_stall_stable got=%h required=%h", mData, prevData);
        end
      end
`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
      checks++;
      if (xferCnt !== 16'(cntModel)) begin
        errors++;
        $display("[TB] FAIL random_cnt got=%h required=%h", xferCnt, 16'(cntModel));
      end
`endif
      if (mValid && mReady) begin
        checks++;
        expV = (expQ.size() != 0) ? expQ.pop_front() : 8'hXX;
        if (mData !== expV) begin
          errors++;
          $display("[TB] FAIL random_beat got=%h required=%h", mData, expV);
        end
      end
      prevStall = mValid && !mReady && !flush;
      prevData = mData;
      advance();
    end
    flush = 1'b0; push = 1'b0; mReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (mValid && mReady) begin
        checks++;
        expV = (expQ.size() != 0) ? expQ.pop_front() : 8'hXX;
        if (mData !== expV) begin
          errors++;
          $display("[TB] FAIL drain_beat got=%h required=%h", mData, expV);
        end
      end
      advance();
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_lost left=%0d required=0", expQ.size());
    end
  endtask

  task automatic test_reset_midstream();
    int nBeats = 0;
    logic [7:0] expV;
    $display("[TB] reset mid-stream");
    mReady = 1'b0;
    for (int c = 0; c < 6; c++) begin
      push = (c < 3);
      pushData = 8'hC0 + 8'(c);
      advance();
    end
    push = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mValid !== 1'b0 || occupancy !== 2'd0 || fifoPop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state valid=%b occ=%0d pop=%b required 0/0/0", mValid, occupancy, fifoPop);
    end
`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
    checks++;
    if (xferCnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midreset_cnt got=%h required=0000", xferCnt);
    end
`endif
    expQ.delete();
    cntModel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b1; pushData = 8'h77; mReady = 1'b1;
    advance();
    push = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mValid && mReady) begin
        checks++;
        nBeats++;
        expV = (expQ.size() != 0) ? expQ.pop_front() : 8'hXX;
        if (mData !== expV) begin
          errors++;
          $display("[TB] FAIL midreset_beat got=%h required=%h", mData, expV);
        end
      end
      advance();
    end
    checks++;
    if (nBeats != 1) begin
      errors++;
      $display("[TB] FAIL midreset_resume beats=%0d required=1", nBeats);
    end
  endtask

`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
  task automatic test_counter_wrap();
    int nBeats = 0;
    logic [7:0] expV;
    $display("[TB] counter wrap");
    flush = 1'b1;
    advance();
    flush = 1'b0;
    mReady = 1'b1;
    for (int c = 0; c < 66000 && nBeats < 65536; c++) begin
      push = !fifoFull;
      pushData = 8'($urandom);
      #1;
      if (mValid && mReady) begin
        nBeats++;
        expV = (expQ.size() != 0) ? expQ.pop_front() : 8'hXX;
        if (mData !== expV) begin
          checks++;
          errors++;
          $display("[TB] FAIL wrap_beat got=%h required=%h", mData, expV);
        end
      end
      advance();
    end
    push = 1'b0;
    mReady = 1'b0;
    #1;
    checks++;
    if (nBeats != 65536 || xferCnt !== 16'h0000 || xferCnt !== 16'(cntModel)) begin
      errors++;
      $display("[TB] FAIL cnt_wrap beats=%0d cnt=%h required 65536/0000", nBeats, xferCnt);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle_ready();
    test_flush();
    test_random();
    test_reset_midstream();
`ifdef SYNC_FIFO_RD_STREAM_CNT_EN
    test_counter_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_rd_stream.md
SYNC_FIFO_RD_STREAM -- requirements
Module: sync_fifo_rd_stream

Interface
REQ-001 Parameter: WIDTH, 8, data width; must match the upstream sync FIFO WIDTH.
REQ-002 clk  input  1  rising-edge clock; one clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous clear; the same signal drives the upstream FIFO flush.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_data  input  WIDTH  upstream FIFO data_out; valid one cycle after fifo_pop.
REQ-007 fifo_pop  output  1  pop request to the upstream FIFO.
REQ-008 m_valid  output  1  stream data valid.
REQ-009 m_ready  input  1  stream consumer ready.
REQ-010 m_data  output  WIDTH  stream data; head of the skid buffer.
REQ-011 occupancy  output  2  entries held in the skid buffer (0..2).

Function
REQ-012 Skid buffer SHALL hold 2 entries in FIFO order; states EMPTY, ONE, TWO; occupancy encodes the state (0/1/2).
REQ-013 inflight SHALL be a register set to 1 the cycle after fifo_pop=1, else 0.
REQ-014 xfer SHALL be m_valid & m_ready; a beat SHALL transfer only on xfer=1.
REQ-015 fifo_pop SHALL be !fifo_empty & !flush & ((occupancy + inflight - xfer) < 2); combinational from m_ready is permitted.
REQ-016 Data SHALL be captured from fifo_data on the edge ending each cycle where inflight=1 (and flush=0).
REQ-017 Latency: FIFO non-empty at cycle 0 with empty buffer -> fifo_pop in cycle 0, m_valid=1 from cycle 2 with the first FIFO word.
REQ-018 Throughput: with the FIFO non-empty and m_ready held 1, one beat SHALL transfer every cycle with no bubble after the first.
REQ-019 m_valid SHALL equal (occupancy != 0); m_data SHALL stay stable while m_valid=1 & m_ready=0.
REQ-020 Capture and xfer in the same cycle SHALL leave occupancy unchanged; the incoming word goes behind the remaining entry.
REQ-021 occupancy SHALL never exceed 2; a capture with occupancy=2 and xfer=0 is unreachable by REQ-015.
REQ-022 Transitions: EMPTY->ONE on capture; ONE->TWO on capture & !xfer; ONE->EMPTY on xfer & !capture; TWO->ONE on xfer & !capture; all others hold.
REQ-023 flush=1 SHALL force fifo_pop=0, clear the buffer to EMPTY and clear inflight on the next edge; a word returning from a pop issued the cycle before flush SHALL be discarded.
REQ-024 During flush m_valid SHALL still reflect the current occupancy; an xfer in the flush cycle counts as delivered.

Reset
REQ-025 rst_n=0 SHALL asynchronously force EMPTY, inflight=0, occupancy=0, m_valid=0, m_data=0, fifo_pop=0.
REQ-026 Reset mid-stream SHALL discard all buffered and in-flight data; operation resumes on the first edge after rst_n deasserts.

Configuration
REQ-027 Macro SYNC_FIFO_RD_STREAM_CNT_EN defined: output xfer_cnt [15:0] SHALL exist; it is cleared by reset and flush, increments on each xfer and wraps 0xFFFF->0x0000.
REQ-028 Macro undefined: the xfer_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package sync_fifo_pkg SHALL hold the state enum skid_state_e (SKID_EMPTY, SKID_ONE, SKID_TWO) and the constant SKID_DEPTH=2.
REQ-030 No sub-module; a single module containing the buffer, the pop control and the optional counter.

Verification
REQ-031 Bench SHALL instantiate sync_fifo (DEPTH=4) upstream with a shared clk, rst_n and flush; checks occur on posedge+1.
REQ-032 Push 0x00..0x03 with m_ready=1 -> m_data 0x00,0x01,0x02,0x03 on four consecutive xfers; the first m_valid comes 2 cycles after the first fifo_pop.
REQ-033 Push 0x10..0x13 with m_ready=0 -> occupancy=2, fifo_pop=0, FIFO level=2, m_data=0x10 stable; raise m_ready -> 0x10..0x13 in order, back-to-back.
REQ-034 Toggle m_ready 1/0 every cycle over 8 pushed words 0xA0..0xA7 -> no loss or duplication; occupancy stays <=2.
REQ-035 Assert flush the cycle after a fifo_pop with occupancy=1 -> next cycle occupancy=0, m_valid=0, FIFO empty; a later push of 0x55 emerges as the first beat.
REQ-036 Drop rst_n mid-stream between edges -> m_valid=0 and occupancy=0 immediately; with CNT_EN defined, xfer_cnt=0; after 0xFFFF+1 beats, xfer_cnt wraps to 0.
